// File: rtl/mem_line_arbiter.sv
// Round-robin arbiter sequencing whole-line READ_LINE/WRITE_LINE transactions from two cache
// requesters onto one beat-wide memory bus. Optional WAIT_RSP watchdog under MEM_ARB_TIMEOUT_EN.
module mem_line_arbiter #(
    parameter int ADDR_W         = 15,
    parameter int DATA_W         = 16,
    parameter int BEATS          = 8,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    clk,
    input  logic                    RESET_N,
    input  logic [1:0]              req,
    input  logic [1:0]              req_wr,
    input  logic [ADDR_W-1:0]       req_addr0,
    input  logic [ADDR_W-1:0]       req_addr1,
    input  logic [BEATS*DATA_W-1:0] req_wline0,
    input  logic [BEATS*DATA_W-1:0] req_wline1,
    output logic [1:0]              gnt,
    output logic [1:0]              done,
    output logic [BEATS*DATA_W-1:0] rline,
    output logic [1:0]              err,
    output logic                    busy,
    output logic [1:0]              mem_cmd,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [DATA_W-1:0]       mem_wdata,
    input  logic [1:0]              mem_rsp,
    input  logic [DATA_W-1:0]       mem_rdata
);
    localparam int LINE_W = BEATS * DATA_W;
    localparam int BCW    = $clog2(BEATS);
    localparam logic [1:0]     CMD_NOP   = 2'd0;
    localparam logic [1:0]     CMD_RD    = 2'd2;
    localparam logic [1:0]     CMD_WR    = 2'd3;
    localparam logic [1:0]     RSP_OK    = 2'd1;
    localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS - 1);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WR_BEAT, S_WAIT_RSP, S_RD_BEAT, S_DONE} state_t;

    state_t            state_q, state_n;
    logic              gsel, op_wr, rr_last, grant_idx, rsp_ok, timeout;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] line_q;
    logic [BCW-1:0]    beat_cnt;

    // Both requesting: the one not served last wins.
    assign grant_idx = (req == 2'b11) ? ~rr_last : req[1];
    assign rsp_ok    = (mem_rsp == RSP_OK);
    assign busy      = (state_q != S_IDLE);
    assign err       = timeout ? (2'b01 << gsel) : 2'b00;

`ifdef MEM_ARB_TIMEOUT_EN
    logic [15:0] wd_cnt;

    assign timeout = (state_q == S_WAIT_RSP) && !rsp_ok && (wd_cnt == 16'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N)                   wd_cnt <= '0;
        else if (state_q != S_WAIT_RSP) wd_cnt <= '0;
        else                            wd_cnt <= wd_cnt + 16'd1;
    end
`else
    // No watchdog: constant false.
    assign timeout = (TIMEOUT_CYCLES < 0);
`endif

    always_comb begin
        state_n   = state_q;
        mem_cmd   = CMD_NOP;
        mem_addr  = '0;
        mem_wdata = '0;
        done      = 2'b00;
        case (state_q)
            S_IDLE: if (req != 2'b00) state_n = S_ISSUE;
            S_ISSUE: begin
                mem_cmd  = op_wr ? CMD_WR : CMD_RD;
                mem_addr = addr_q;
                if (op_wr) begin
                    mem_wdata = line_q[DATA_W-1:0];
                    state_n   = S_WR_BEAT;
                end else begin
                    state_n = S_WAIT_RSP;
                end
            end
            S_WR_BEAT: begin
                mem_cmd   = CMD_WR;
                mem_addr  = addr_q;
                mem_wdata = line_q[beat_cnt*DATA_W +: DATA_W];
                if (beat_cnt == LAST_BEAT) state_n = S_WAIT_RSP;
            end
            S_WAIT_RSP: begin
                if (rsp_ok)       state_n = op_wr ? S_DONE : S_RD_BEAT;
                else if (timeout) state_n = S_IDLE;
            end
            // The beat count, not mem_rsp, decides when the burst ends.
            S_RD_BEAT: if (beat_cnt == LAST_BEAT) state_n = S_DONE;
            S_DONE: begin
                done    = 2'b01 << gsel;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= S_IDLE;
            gsel     <= 1'b0;
            op_wr    <= 1'b0;
            addr_q   <= '0;
            line_q   <= '0;
            beat_cnt <= '0;
            rline    <= '0;
            rr_last  <= 1'b1;
            gnt      <= 2'b00;
        end else begin
            state_q <= state_n;
            case (state_q)
                S_IDLE: if (req != 2'b00) begin
                    gsel     <= grant_idx;
                    op_wr    <= req_wr[grant_idx];
                    addr_q   <= grant_idx ? req_addr1 : req_addr0;
                    line_q   <= grant_idx ? req_wline1 : req_wline0;
                    beat_cnt <= '0;
                    gnt      <= 2'b01 << grant_idx;
                end
                S_ISSUE:   beat_cnt <= op_wr ? BCW'(1) : '0;
                S_WR_BEAT: beat_cnt <= beat_cnt + BCW'(1);
                S_WAIT_RSP: begin
                    if (rsp_ok && !op_wr) begin
                        line_q[DATA_W-1:0] <= mem_rdata;
                        beat_cnt           <= BCW'(1);
                    end else if (timeout) begin
                        gnt     <= 2'b00;
                        rr_last <= gsel;
                    end
                end
                S_RD_BEAT: begin
                    line_q[beat_cnt*DATA_W +: DATA_W] <= mem_rdata;
                    beat_cnt                          <= beat_cnt + BCW'(1);
                    if (beat_cnt == LAST_BEAT)
                        rline <= {mem_rdata, line_q[LINE_W-DATA_W-1:0]};
                end
                S_DONE: begin
                    gnt     <= 2'b00;
                    rr_last <= gsel;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_line_arbiter.sv
// Directed + randomized bench for mem_line_arbiter with a transaction-level reference model
// and a bench-side memory responder.
module tb_mem_line_arbiter;
    localparam int TO = 16;

    logic         clk = 1'b0;
    logic         RESET_N;
    logic [1:0]   req, req_wr, gnt, done, err, mem_cmd, mem_rsp;
    logic [14:0]  req_addr0, req_addr1, mem_addr;
    logic [127:0] req_wline0, req_wline1, rline;
    logic         busy;
    logic [15:0]  mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    mem_line_arbiter #(.ADDR_W(15), .DATA_W(16), .BEATS(8), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .RESET_N(RESET_N), .req(req), .req_wr(req_wr),
        .req_addr0(req_addr0), .req_addr1(req_addr1),
        .req_wline0(req_wline0), .req_wline1(req_wline1),
        .gnt(gnt), .done(done), .rline(rline), .err(err), .busy(busy),
        .mem_cmd(mem_cmd), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rsp(mem_rsp), .mem_rdata(mem_rdata)
    );

    int           nrun = 0, nfail = 0;
    logic         rr_last_m;
    logic [127:0] rline_m;
    logic [15:0]  rd_beats[8];
    int           lat, hole, drop_at, rst_at;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] want);
        nrun++;
        assert (obs === want) else begin
            nfail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, want);
        end
    endtask

    function automatic int pick(input logic [1:0] r, input logic rr);
        if (r == 2'b11) return rr ? 0 : 1;
        return r[1] ? 1 : 0;
    endfunction

    task automatic scramble();
        req_wr     = 2'($urandom);
        req_addr0  = 15'($urandom);
        req_addr1  = 15'($urandom);
        req_wline0 = {$urandom, $urandom, $urandom, $urandom};
        req_wline1 = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // Called at a negedge inside an IDLE cycle; request inputs already set up by the caller.
    task automatic txn(input logic [1:0] r, input string tag);
        int g, ncmd, first_cmd, done_at, gnt_bad, data_bad, wait_k, sidx, nsend;
        logic seen, wr, aborted;
        logic [14:0]  a;
        logic [127:0] wl, rline_v;
        logic [1:0]   done_v, gnt_v;
        ncmd = 0; first_cmd = -1; done_at = -1; gnt_bad = 0; data_bad = 0;
        wait_k = 0; sidx = -1; seen = 1'b0; aborted = 1'b0;
        rline_v = '0; done_v = '0; gnt_v = '0;
        req   = r;
        g     = pick(r, rr_last_m);
        wr    = req_wr[g];
        a     = g ? req_addr1 : req_addr0;
        wl    = g ? req_wline1 : req_wline0;
        nsend = wr ? 1 : 8;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (c == 1) scramble();
            if (c == drop_at) req = 2'b00;
            if (c == rst_at) begin
                RESET_N = 1'b0;
                #1;
                chk($sformatf("%s_rst_gnt", tag), gnt, 0);
                chk($sformatf("%s_rst_cmd", tag), mem_cmd, 0);
                chk($sformatf("%s_rst_busy", tag), busy, 0);
                chk($sformatf("%s_rst_nodone", tag), done_at, -1);
                rr_last_m = 1'b1;
                rline_m   = '0;
                aborted   = 1'b1;
                break;
            end
            if (mem_cmd != 2'd0) begin
                if (first_cmd < 0) first_cmd = c;
                if (mem_cmd !== (wr ? 2'd3 : 2'd2) || mem_addr !== a) data_bad++;
                if (wr && (ncmd >= 8 || mem_wdata !== wl[16*ncmd +: 16])) data_bad++;
                ncmd++;
                seen = 1'b1;
            end
            if (done != 2'b00) begin
                done_at = c; done_v = done; rline_v = rline; gnt_v = gnt;
                break;
            end
            if (gnt !== (2'b01 << g) || err !== 2'b00) gnt_bad++;
            // Stray responses while commands are on the bus must be ignored.
            mem_rsp   = (mem_cmd != 2'd0) ? {1'b0, 1'($urandom)} : 2'd0;
            mem_rdata = 16'($urandom);
            if (seen && mem_cmd == 2'd0) begin
                if (sidx < 0) begin
                    if (wait_k >= lat) sidx = 0;
                    else wait_k++;
                end
                if (sidx >= 0 && sidx < nsend) begin
                    mem_rsp   = (sidx == hole) ? 2'd2 : 2'd1;
                    mem_rdata = wr ? 16'($urandom) : rd_beats[sidx];
                    sidx++;
                end
            end
        end
        mem_rsp = 2'd0;
        req     = 2'b00;
        if (!aborted) begin
            chk($sformatf("%s_ncmd", tag), ncmd, wr ? 8 : 1);
            chk($sformatf("%s_first_cmd", tag), first_cmd, 0);
            chk($sformatf("%s_bus_data", tag), data_bad, 0);
            chk($sformatf("%s_gnt_hold", tag), gnt_bad, 0);
            chk($sformatf("%s_done_lat", tag), done_at, 9 + lat);
            chk($sformatf("%s_done_who", tag), done_v, 2'b01 << g);
            chk($sformatf("%s_gnt_at_done", tag), gnt_v, 2'b01 << g);
            if (!wr) for (int i = 0; i < 8; i++) rline_m[16*i +: 16] = rd_beats[i];
            chk($sformatf("%s_rline", tag), rline_v, rline_m);
            rr_last_m = 1'(g);
            @(negedge clk);
            chk($sformatf("%s_idle_gap", tag), {busy, gnt, done}, 0);
        end
    endtask

    initial begin
        int   first_err, busy_after, busy_lost, done_seen, err_seen;
        logic [1:0] err_v;
        RESET_N = 1'b0; req = 2'b00; mem_rsp = 2'd0; mem_rdata = '0;
        req_wr = '0; req_addr0 = '0; req_addr1 = '0; req_wline0 = '0; req_wline1 = '0;
        rr_last_m = 1'b1; rline_m = '0; lat = 0; hole = -1; drop_at = -1; rst_at = -1;
        repeat (2) @(negedge clk);
        chk("reset_ctl", {gnt, done, err, busy, mem_cmd}, 0);
        chk("reset_bus", {mem_addr, mem_wdata}, 0);
        chk("reset_rline", rline, 0);
        RESET_N = 1'b1;
        @(negedge clk);

        // Read from requester 0 with a slow memory
        req_wr = 2'b00; req_addr0 = 15'h0012;
        for (int i = 0; i < 8; i++) rd_beats[i] = 16'(i + 1);
        lat = 200;
        txn(2'b01, "rd_slow");
        chk("rd_slow_value", rline, 128'h0008_0007_0006_0005_0004_0003_0002_0001);

        // Write from requester 1 at the top address
        req_wr = 2'b10; req_addr1 = 15'h7FFF;
        req_wline1 = 128'hFFFF_EEEE_DDDD_CCCC_BBBB_AAAA_9999_8888;
        lat = 3;
        txn(2'b10, "wr_top");
        chk("wr_keeps_rline", rline, rline_m);

        // Both held: alternates starting with requester 0
        for (int k = 0; k < 4; k++) begin
            scramble();
            for (int i = 0; i < 8; i++) rd_beats[i] = 16'($urandom);
            lat = $urandom_range(0, 5);
            txn(2'b11, $sformatf("rr%0d", k));
        end

        // Request dropped during the write burst
        req_wr = 2'b01; req_wline0 = {$urandom, $urandom, $urandom, $urandom};
        lat = 1; drop_at = 3;
        txn(2'b01, "wr_drop");
        drop_at = -1;

        // Randomized traffic, including non-response gaps inside read bursts
        for (int k = 0; k < 10; k++) begin
            scramble();
            for (int i = 0; i < 8; i++) rd_beats[i] = 16'($urandom);
            lat     = $urandom_range(0, 20);
            hole    = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 7)) : -1;
            drop_at = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 5)) : -1;
            txn(2'($urandom_range(1, 3)), $sformatf("rnd%0d", k));
        end
        hole = -1; drop_at = -1;

        // Asynchronous reset while beat 3 of a read is being captured
        req_wr = 2'b00; req_addr0 = 15'h0100; lat = 0; rst_at = 4;
        txn(2'b01, "rst_mid");
        rst_at = -1;
        @(negedge clk);
        RESET_N = 1'b1;
        done_seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (done != 2'b00 || busy) done_seen++;
        end
        chk("rst_mid_quiet", done_seen, 0);
        chk("rst_mid_rline", rline, 0);

        // No memory response at all
        req_wr = 2'b00; req_addr0 = 15'h0ABC; req = 2'b01;
        first_err = -1; busy_after = -1; busy_lost = 0; done_seen = 0; err_seen = 0; err_v = '0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (c == 1) req = 2'b00;
            if (err != 2'b00) err_seen++;
            if (err != 2'b00 && first_err < 0) begin first_err = c; err_v = err; end
            if (first_err >= 0 && c == first_err + 1) busy_after = int'(busy);
            if (done != 2'b00) done_seen++;
            if (!busy) busy_lost++;
            mem_rsp = 2'd0;
        end
        chk("to_no_done", done_seen, 0);
`ifdef MEM_ARB_TIMEOUT_EN
        chk("to_err_time", first_err, 1 + TO);
        chk("to_err_who", err_v, 2'b01);
        chk("to_busy_after", busy_after, 0);
        chk("to_rline_kept", rline, 0);
`else
        chk("to_busy_held", busy_lost, 0);
        chk("to_err_zero", err_seen, 0);
`endif
        RESET_N = 1'b0;
        @(negedge clk);
        RESET_N = 1'b1;
        @(negedge clk);
        chk("final_idle", {busy, gnt}, 0);

        $display("[TB] %0d tests run, %0d failed", nrun, nfail);
        $finish;
    end
endmodule
